ps2_rx_frame_ctrl: RTL and testbench
====================================

PS2_RX_FRAME_CTRL -- requirements
Module: ps2_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synced samples required before filtered ps2_clk changes level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port habilitar  input  1  permits a new frame to start.
REQ-008 SHALL have port dato  output  8  last valid received byte.
REQ-009 SHALL have port cod_verificado  output  1  one-cycle pulse: dato updated with a good frame.
REQ-010 SHALL have port error_trama  output  1  one-cycle pulse: frame aborted (parity, stop or timeout).
REQ-011 SHALL have port ocupado  output  1  high while state is not IDLE.

Function
REQ-012 SHALL synchronise ps2_clk and ps2_data through two flip-flops each before any use.
REQ-013 SHALL change filtered clock only after FILTER_LEN consecutive identical synced ps2_clk samples.
REQ-014 SHALL produce a one-cycle falling-edge strobe (fe) when filtered clock goes 1->0; ps2_data sampled from its synced value in the fe cycle.
REQ-015 SHALL implement FSM states IDLE, RECV, CHECK.
REQ-016 IDLE: on fe with habilitar=1 and sampled data=0 (start bit) -> RECV, bit counter=1; on fe with data=1, stay IDLE, no pulse (glitch ignored); on fe with habilitar=0, stay IDLE.
REQ-017 RECV: each fe shifts in one bit; bits 1..8 data LSB first, bit 9 parity, bit 10 stop; on fe sampling bit 10 -> CHECK.
REQ-018 CHECK (one cycle): if ones(data)+parity is odd and stop=1, load dato and pulse cod_verificado; else pulse error_trama, dato unchanged; always -> IDLE.
REQ-019 Latency: cod_verificado/error_trama high exactly one clk cycle after the fe sampling the stop bit.
REQ-020 RECV SHALL count clk cycles since last fe; counter clears on each fe; reaching TIMEOUT_CYCLES -> pulse error_trama next cycle, -> IDLE, shift register and bit counter cleared.
REQ-021 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1); counter SHALL not wrap.
REQ-022 habilitar SHALL be examined only in IDLE; deassertion mid-frame SHALL not abort the frame.
REQ-023 cod_verificado and error_trama SHALL never be high in the same cycle.
REQ-024 fe arriving in the CHECK cycle SHALL be ignored (no valid start can occur there per PS/2 timing).
REQ-025 ocupado SHALL be high in RECV and CHECK, low in IDLE.

Reset
REQ-026 rst=0 SHALL asynchronously force: state IDLE, dato=8'h00, cod_verificado=0, error_trama=0, ocupado=0, counters, shift register, synchronisers cleared, filtered clock=1.
REQ-027 Reset mid-frame SHALL discard the partial frame with no pulse on either strobe after release.

Structure
REQ-028 Shared package SHALL hold state encoding, FRAME_BITS=11, DATA_BITS=8.
REQ-029 SHALL instantiate one sub-module ps2_sync_filter (synchronisers, FILTER_LEN filter, fe strobe, synced data out).
REQ-030 All outputs SHALL be driven from registers.

Verification
REQ-031 Good frame 0x1C (parity 0, stop 1) -> dato=8'h1C, cod_verificado one pulse one cycle after stop fe, error_trama never high.
REQ-032 Frame 0x1C with parity 1 -> error_trama one pulse, dato keeps previous value (8'h00 after reset), cod_verificado low.
REQ-033 Five bits sent then idle -> error_trama pulse TIMEOUT_CYCLES+1 cycles after last fe, ocupado falls; next frame 0xF0 (parity 1) -> dato=8'hF0 with cod_verificado pulse.
REQ-034 3-cycle low glitch on ps2_clk with FILTER_LEN=8 -> no fe, state stays IDLE, ocupado stays 0.
REQ-035 rst=0 after bit 6 of frame 0x5A, then release, then full frame 0x29 -> no strobe from aborted frame, dato=8'h29.
REQ-036 habilitar=0 during start-bit fe -> frame ignored, ocupado 0; habilitar dropped after start bit -> frame completes normally.

Source files
------------

// File: rtl/ps2_rx_frame_ctrl_pkg.sv
// Shared constants for the PS/2 receive frame controller: FSM encoding,
// frame geometry and the frame acceptance rule.
package ps2_rx_frame_ctrl_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] data,
                                    input logic                 parity,
                                    input logic                 stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_rx_frame_ctrl_sync_filter.sv
// PS/2 line conditioning: two-flop synchronisers, a run-length glitch filter on
// the clock line and a registered falling-edge strobe of the filtered clock.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fe,
  output logic data_sync
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
      r_filt   <= 1'b1;
      r_cnt    <= '0;
      r_fe     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fe     <= 1'b0;
      // r_cnt tracks the current run of samples disagreeing with r_filt
      if (r_clk_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_clk_s2;
        r_cnt  <= '0;
        r_fe   <= ~r_clk_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign fe        = r_fe;
  assign data_sync = r_dat_s2;

endmodule

// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 device-to-host frame receiver: collects start/8 data/parity/stop bits on
// filtered falling edges, validates the frame and reports it with one-cycle strobes.
module ps2_rx_frame_ctrl
  import ps2_rx_frame_ctrl_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       habilitar,
  output logic [7:0] dato,
  output logic       cod_verificado,
  output logic       error_trama,
  output logic       ocupado
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(FRAME_BITS + 1);
  localparam int SW  = FRAME_BITS - 2;
  localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);

  logic                 w_fe;
  logic                 w_data;
  logic [SW:0]          w_frame;
  logic [TW-1:0]        w_to_next;

  logic [1:0]           r_state;
  logic [BCW-1:0]       r_bit_cnt;
  logic [SW-1:0]        r_shift;
  logic [TW-1:0]        r_to_cnt;
  logic [DATA_BITS-1:0] r_dato;
  logic                 r_cod;
  logic                 r_err;
  logic                 r_ocupado;

  logic [1:0]           w_state_d;
  logic [BCW-1:0]       w_bit_cnt_d;
  logic [SW-1:0]        w_shift_d;
  logic [TW-1:0]        w_to_cnt_d;
  logic [DATA_BITS-1:0] w_dato_d;
  logic                 w_cod_d;
  logic                 w_err_d;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fe        (w_fe),
    .data_sync (w_data)
  );

  // Frame as it stands once the bit on the current edge is included.
  assign w_frame   = {w_data, r_shift};
  assign w_to_next = r_to_cnt + 1'b1;

  always_comb begin
    w_state_d   = r_state;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_to_cnt_d  = r_to_cnt;
    w_dato_d    = r_dato;
    w_cod_d     = 1'b0;
    w_err_d     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_to_cnt_d = '0;
        if (w_fe && habilitar && !w_data) begin
          w_state_d   = ST_RECV;
          w_bit_cnt_d = BCW'(1);
          w_shift_d   = '0;
        end
      end
      ST_RECV: begin
        if (w_fe) begin
          w_to_cnt_d = '0;
          w_shift_d  = w_frame[SW:1];
          if (r_bit_cnt == LAST_BIT) begin
            // Verdict is registered on the stop edge so the strobe lands in CHECK.
            w_state_d   = ST_CHECK;
            w_bit_cnt_d = '0;
            if (frame_ok(w_frame[DATA_BITS-1:0], w_frame[DATA_BITS], w_frame[DATA_BITS+1])) begin
              w_dato_d = w_frame[DATA_BITS-1:0];
              w_cod_d  = 1'b1;
            end else begin
              w_err_d = 1'b1;
            end
          end else begin
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end else if (w_to_next == TO_LIMIT) begin
          w_state_d   = ST_IDLE;
          w_err_d     = 1'b1;
          w_shift_d   = '0;
          w_bit_cnt_d = '0;
          w_to_cnt_d  = '0;
        end else begin
          w_to_cnt_d = w_to_next;
        end
      end
      ST_CHECK: begin
        w_state_d = ST_IDLE;
        w_shift_d = '0;
      end
      default: begin
        w_state_d   = ST_IDLE;
        w_bit_cnt_d = '0;
        w_shift_d   = '0;
        w_to_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_to_cnt  <= '0;
      r_dato    <= '0;
      r_cod     <= 1'b0;
      r_err     <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_to_cnt  <= w_to_cnt_d;
      r_dato    <= w_dato_d;
      r_cod     <= w_cod_d;
      r_err     <= w_err_d;
      r_ocupado <= (w_state_d != ST_IDLE);
    end
  end

  assign dato           = r_dato;
  assign cod_verificado = r_cod;
  assign error_trama    = r_err;
  assign ocupado        = r_ocupado;

endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// Directed and randomized frames against a frame-level reference model of the
// PS/2 receiver: expected byte, strobe counts and strobe timing per frame.
module tb_ps2_rx_frame_ctrl;

  localparam int FL  = 8;
  localparam int TC  = 300;
  localparam int H   = 30;
  // Raw clock fall -> fe: 2 sync flops + FL filter samples; strobe one cycle later.
  localparam int FE_LAT  = FL + 2;
  localparam int STB_LAT = FE_LAT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       habilitar = 1'b0;
  logic [7:0] dato;
  logic       cod_verificado;
  logic       error_trama;
  logic       ocupado;

  ps2_rx_frame_ctrl #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .habilitar      (habilitar),
    .dato           (dato),
    .cod_verificado (cod_verificado),
    .error_trama    (error_trama),
    .ocupado        (ocupado)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cod = 0;
  int n_err = 0;
  int n_both = 0;
  int last_cod_cyc = -1;
  int last_err_cyc = -1;
  int last_fall = 0;

  always @(negedge clk) begin
    if (cod_verificado) begin
      n_cod        <= n_cod + 1;
      last_cod_cyc <= cyc;
    end
    if (error_trama) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    if (cod_verificado && error_trama) n_both <= n_both + 1;
  end

  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] model_dato = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] data, input bit bad_par,
                                           input bit stop);
    logic par;
    par = (($countones(data) % 2) == 0) ^ bad_par;
    return {stop, par, data, 1'b0};
  endfunction

  // Data changes while the clock is high; each bit is taken on the falling edge.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit drop_hab,
                           input bit exp_busy);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      repeat (H) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (H) @(negedge clk);
      if (i == 0 && drop_hab) habilitar = 1'b0;
      if (i == 1) chk("busy_mid_frame", 32'(ocupado), 32'(exp_busy));
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] data, input bit bad_par,
                           input bit stop, input bit drop_hab);
    int          c0;
    int          e0;
    bit          good;
    logic [10:0] fr;
    c0   = n_cod;
    e0   = n_err;
    fr   = mk_frame(data, bad_par, stop);
    good = fr[10] && ((($countones(fr[8:1]) + int'(fr[9])) % 2) == 1);
    send_bits(fr, 11, drop_hab, 1'b1);
    if (good) model_dato = data;
    chk({tag, "_dato"}, 32'(dato), 32'(model_dato));
    chk({tag, "_cod_cnt"}, 32'(n_cod - c0), good ? 32'd1 : 32'd0);
    chk({tag, "_err_cnt"}, 32'(n_err - e0), good ? 32'd0 : 32'd1);
    if (good) chk({tag, "_cod_time"}, 32'(last_cod_cyc), 32'(last_fall + STB_LAT));
    else      chk({tag, "_err_time"}, 32'(last_err_cyc), 32'(last_fall + STB_LAT));
    chk({tag, "_idle_after"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    int c0;
    int e0;
    repeat (3) @(negedge clk);
    chk("rst_dato", 32'(dato), 32'h00);
    chk("rst_cod", 32'(cod_verificado), 32'd0);
    chk("rst_err", 32'(error_trama), 32'd0);
    chk("rst_busy", 32'(ocupado), 32'd0);
    rst = 1'b1;
    habilitar = 1'b1;
    repeat (20) @(negedge clk);

    run_frame("bad_parity_1c", 8'h1C, 1'b1, 1'b1, 1'b0);
    run_frame("good_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    run_frame("bad_stop_a7", 8'hA7, 1'b0, 1'b0, 1'b0);

    // Partial frame then silence.
    c0 = n_cod;
    e0 = n_err;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5, 1'b0, 1'b1);
    repeat (TC + 60) @(negedge clk);
    chk("timeout_err_cnt", 32'(n_err - e0), 32'd1);
    chk("timeout_cod_cnt", 32'(n_cod - c0), 32'd0);
    chk("timeout_err_time", 32'(last_err_cyc), 32'(last_fall + FE_LAT + TC + 1));
    chk("timeout_busy", 32'(ocupado), 32'd0);
    chk("timeout_dato", 32'(dato), 32'(model_dato));
    run_frame("after_timeout_f0", 8'hF0, 1'b0, 1'b1, 1'b0);

    // Short low glitch with data low: a real edge here would start a frame.
    c0 = n_cod;
    e0 = n_err;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_busy", 32'(ocupado), 32'd0);
    chk("glitch_strobes", 32'((n_cod - c0) + (n_err - e0)), 32'd0);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of a frame.
    c0 = n_cod;
    e0 = n_err;
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 7, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_dato = 8'h00;
    chk("midrst_dato", 32'(dato), 32'(model_dato));
    chk("midrst_busy", 32'(ocupado), 32'd0);
    rst = 1'b1;
    repeat (TC + 60) @(negedge clk);
    chk("midrst_strobes", 32'((n_cod - c0) + (n_err - e0)), 32'd0);
    chk("midrst_busy_after", 32'(ocupado), 32'd0);
    run_frame("after_rst_29", 8'h29, 1'b0, 1'b1, 1'b0);

    // Start edge while disabled: whole frame ignored.
    c0 = n_cod;
    e0 = n_err;
    habilitar = 1'b0;
    send_bits(mk_frame(8'h33, 1'b0, 1'b1), 11, 1'b0, 1'b0);
    chk("disabled_strobes", 32'((n_cod - c0) + (n_err - e0)), 32'd0);
    chk("disabled_dato", 32'(dato), 32'(model_dato));
    chk("disabled_busy", 32'(ocupado), 32'd0);
    habilitar = 1'b1;
    run_frame("hab_drop_74", 8'h74, 1'b0, 1'b1, 1'b1);
    habilitar = 1'b1;

    for (int k = 0; k < 8; k++) begin
      logic [7:0] d;
      bit         bp;
      bit         st;
      d  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) != 0);
      run_frame("rand", d, bp, st, 1'b0);
    end

    chk("never_both_strobes", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
